// File: rtl/decode_exec_unit_pkg.sv
// decode_exec_unit_pkg: opcodes, flag indices and FSM encoding shared by the decode/execute unit
package decode_exec_unit_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_CMP  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_INC  = 4'h3;
    localparam logic [3:0] OP_MOV  = 4'h4;
    localparam logic [3:0] OP_LD   = 4'h5;
    localparam logic [3:0] OP_ST   = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h7;
    localparam logic [3:0] OP_JMP0 = 4'h8;
    localparam logic [3:0] OP_JMP1 = 4'h9;

    localparam int F_ZERO  = 0;
    localparam int F_CARRY = 1;
    localparam int F_NEG   = 2;
    localparam int F_GE    = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_MEM_WAIT
    } state_e;

    typedef enum logic {
        ALU_ADD,
        ALU_SUB
    } alu_op_e;

endpackage

// File: rtl/decode_exec_alu.sv
// decode_exec_alu: combinational add/subtract with carry (borrow on subtract), zero and negative
module decode_exec_alu
    import decode_exec_unit_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  alu_op_e       op_i,
    output logic [DW-1:0] result_o,
    output logic          carry_o,
    output logic          zero_o,
    output logic          neg_o
);

    logic [DW:0] sum;

    // One extra bit holds carry out, or the borrow when a < b on subtract
    assign sum      = (op_i == ALU_SUB) ? {1'b0, a_i} - {1'b0, b_i} : {1'b0, a_i} + {1'b0, b_i};
    assign result_o = sum[DW-1:0];
    assign carry_o  = sum[DW];
    assign zero_o   = (sum[DW-1:0] == '0);
    assign neg_o    = sum[DW-1];

endmodule

// File: rtl/decode_exec_unit.sv
// decode_exec_unit: one-at-a-time instruction decode/execute with register file and req/ack data port
module decode_exec_unit
    import decode_exec_unit_pkg::*;
#(
    parameter  int DW  = 8,
    parameter  int RAW = 5,
    localparam int IW  = 4 + 3 * RAW
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [IW-1:0]  instr,
    output logic           mem_req,
    output logic           mem_we,
    output logic [DW-1:0]  mem_addr,
    output logic [DW-1:0]  mem_wdata,
    input  logic           mem_ack,
    input  logic [DW-1:0]  mem_rdata,
    output logic           jump_valid,
    output logic [RAW-1:0] jump_target,
    output logic [3:0]     flags,
    output logic           illegal
);

    localparam int NREG = 2 ** RAW;

    state_e          state_q;
    logic [IW-1:0]   instr_q;
    logic [DW-1:0]   regs_q [NREG];
    logic [3:0]      flags_q;
    logic [3:0]      flags_d;
    logic            illegal_q;
    logic            mem_we_q;
    logic [DW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic            jump_valid_q;
    logic [RAW-1:0]  jump_target_q;

    logic [3:0]      op;
    logic [RAW-1:0]  fa;
    logic [RAW-1:0]  fb;
    logic [RAW-1:0]  fc;
    logic [DW-1:0]   ra;
    logic [DW-1:0]   rb;
    logic [DW-1:0]   rc;
    logic [DW-1:0]   alu_a;
    logic [DW-1:0]   alu_b;
    alu_op_e         alu_op;
    logic [DW-1:0]   alu_res;
    logic            alu_carry;
    logic            alu_zero;
    logic            alu_neg;
    logic            rf_we;
    logic [RAW-1:0]  rf_waddr;
    logic [DW-1:0]   rf_wdata;
    logic            jump_cond;
    logic            jump_take;

    assign {op, fa, fb, fc} = instr_q;
    assign ra = regs_q[fa];
    assign rb = regs_q[fb];
    assign rc = regs_q[fc];

    // ADD/SUB read fb,fc; INC adds 1 to fa; CMP computes fa - fb and uses the borrow
    assign alu_a  = (op == OP_ADD || op == OP_SUB) ? rb : ra;
    assign alu_b  = (op == OP_INC) ? DW'(1) : (op == OP_CMP) ? rb : rc;
    assign alu_op = (op == OP_SUB || op == OP_CMP) ? ALU_SUB : ALU_ADD;

    decode_exec_alu #(.DW(DW)) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .op_i     (alu_op),
        .result_o (alu_res),
        .carry_o  (alu_carry),
        .zero_o   (alu_zero),
        .neg_o    (alu_neg)
    );

    // Jump is decided at accept time: flags cannot change between accept and EXEC
    assign jump_cond = flags_q[instr[2*RAW +: 2]];
    assign jump_take = (instr[IW-1 -: 4] == OP_JMP0 && !jump_cond) || (instr[IW-1 -: 4] == OP_JMP1 && jump_cond);

    // Register-file write and flag update for the non-memory instruction in EXEC
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = fa;
        rf_wdata = alu_res;
        flags_d  = flags_q;
        case (op)
            OP_ADD, OP_SUB, OP_INC: begin
                rf_we            = 1'b1;
                flags_d[F_ZERO]  = alu_zero;
                flags_d[F_CARRY] = alu_carry;
                flags_d[F_NEG]   = alu_neg;
            end
            OP_CMP: flags_d[F_GE] = ~alu_carry;
            OP_MOV: begin
                rf_we    = 1'b1;
                rf_waddr = fb;
                rf_wdata = ra;
            end
            OP_LDI: begin
                rf_we    = 1'b1;
                rf_wdata = DW'({fb, fc});
            end
            default: ;
        endcase
    end

    // Control FSM with registered memory and jump outputs; register file lives here too
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            regs_q        <= '{default: '0};
            flags_q       <= '0;
            illegal_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            jump_valid_q  <= 1'b0;
            jump_target_q <= '0;
        end else begin
            jump_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q      <= instr;
                        state_q      <= ST_EXEC;
                        jump_valid_q <= jump_take;
                        if (jump_take) jump_target_q <= instr[RAW +: RAW];
                    end
                end
                ST_EXEC: begin
                    if (op == OP_LD || op == OP_ST) begin
                        state_q     <= ST_MEM_WAIT;
                        mem_we_q    <= (op == OP_ST);
                        mem_addr_q  <= (op == OP_ST) ? rb : ra;
                        mem_wdata_q <= ra;
                    end else begin
                        state_q <= ST_IDLE;
                        flags_q <= flags_d;
                        if (rf_we) regs_q[rf_waddr] <= rf_wdata;
                        if (op > OP_JMP1) illegal_q <= 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ack) begin
                        state_q <= ST_IDLE;
                        if (!mem_we_q) regs_q[fb] <= mem_rdata;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign mem_req     = (state_q == ST_MEM_WAIT);
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign jump_valid  = jump_valid_q;
    assign jump_target = jump_target_q;
    assign flags       = flags_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_decode_exec_unit.sv
// tb_decode_exec_unit: randomized self-checking bench with an instruction-level reference model
module tb_decode_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [18:0] instr = '0;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = '0;
    logic        jump_valid;
    logic [4:0]  jump_target;
    logic [3:0]  flags;
    logic        illegal;

    logic        w_instr_valid = 1'b0;
    logic        w_instr_ready;
    logic [15:0] w_instr = '0;
    logic        w_mem_req;
    logic        w_mem_we;
    logic [15:0] w_mem_addr;
    logic [15:0] w_mem_wdata;
    logic        w_mem_ack = 1'b0;
    logic [15:0] w_mem_rdata = '0;
    logic        w_jump_valid;
    logic [3:0]  w_jump_target;
    logic [3:0]  w_flags;
    logic        w_illegal;

    int total = 0;
    int bad = 0;

    logic [7:0] mr [32];
    logic [7:0] mmem [256];
    logic [3:0] mf;
    logic       mill;

    always #5 clk = ~clk;

    decode_exec_unit dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .jump_valid(jump_valid), .jump_target(jump_target),
        .flags(flags), .illegal(illegal)
    );

    decode_exec_unit #(.DW(16), .RAW(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .instr_valid(w_instr_valid), .instr_ready(w_instr_ready), .instr(w_instr),
        .mem_req(w_mem_req), .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata),
        .mem_ack(w_mem_ack), .mem_rdata(w_mem_rdata), .jump_valid(w_jump_valid), .jump_target(w_jump_target),
        .flags(w_flags), .illegal(w_illegal)
    );

    function automatic logic [18:0] enc(input logic [3:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        return {op, a, b, c};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mr[i] = '0;
        mf = '0;
        mill = 1'b0;
    endtask

    // Issue one instruction, check every observable cycle against the model, then update the model
    task automatic exec(input logic [18:0] ins, input int dly);
        logic [3:0] op;
        logic [4:0] a, b, c;
        logic [7:0] ea, ew;
        logic       ej;
        int         s, r;
        {op, a, b, c} = ins;
        total++;
        if (instr_ready !== 1'b1) begin bad++; $display("FAIL ready_idle got=%b want=1", instr_ready); end
        instr = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        instr = 19'($urandom);
        ej = (op == 4'd8 && !mf[a[1:0]]) || (op == 4'd9 && mf[a[1:0]]);
        total++;
        if (instr_ready !== 1'b0) begin bad++; $display("FAIL ready_exec got=%b want=0", instr_ready); end
        total++;
        if (jump_valid !== ej || (ej && jump_target !== b))
            begin bad++; $display("FAIL jump op=%h got=%b/%h want=%b/%h", op, jump_valid, jump_target, ej, b); end
        total++;
        if (mem_req !== 1'b0) begin bad++; $display("FAIL req_exec got=%b want=0", mem_req); end
        if (op == 4'd5 || op == 4'd6) begin
            ea = (op == 4'd6) ? mr[b] : mr[a];
            ew = mr[a];
            for (int k = 1; k <= dly; k++) begin
                @(negedge clk);
                total++;
                if (mem_req !== 1'b1 || mem_we !== (op == 4'd6) || mem_addr !== ea || (op == 4'd6 && mem_wdata !== ew))
                    begin bad++; $display("FAIL mem_port req=%b we=%b addr=%h wd=%h want addr=%h wd=%h", mem_req, mem_we, mem_addr, mem_wdata, ea, ew); end
                if (k == dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = (op == 4'd5) ? mmem[ea] : 8'($urandom);
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            if (op == 4'd6) mmem[ea] = ew;
            else mr[b] = mmem[ea];
        end else begin
            mem_ack = 1'($urandom);
            mem_rdata = 8'($urandom);
            if (op == 4'd0 || op == 4'd2 || op == 4'd3) begin
                s = (op == 4'd0) ? int'(mr[b]) + int'(mr[c]) : (op == 4'd2) ? int'(mr[b]) - int'(mr[c]) : int'(mr[a]) + 1;
                r = (s + 256) % 256;
                mf[0] = (r == 0);
                mf[1] = (s < 0) || (s > 255);
                mf[2] = (r >= 128);
                mr[a] = 8'(r);
            end else if (op == 4'd1) mf[3] = (mr[a] >= mr[b]);
            else if (op == 4'd4) mr[b] = mr[a];
            else if (op == 4'd7) mr[a] = 8'((int'(b) * 32 + int'(c)) % 256);
            else if (op >= 4'd10) mill = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        total++;
        if (flags !== mf) begin bad++; $display("FAIL flags op=%h got=%b want=%b", op, flags, mf); end
        total++;
        if (illegal !== mill) begin bad++; $display("FAIL illegal op=%h got=%b want=%b", op, illegal, mill); end
        total++;
        if (jump_valid !== 1'b0 || mem_req !== 1'b0)
            begin bad++; $display("FAIL idle_outs jump=%b req=%b want 0/0", jump_valid, mem_req); end
    endtask

    // A store of R[r] to address R[r] exposes the register on both mem_addr and mem_wdata
    task automatic peek(input logic [4:0] r);
        exec(enc(4'd6, r, r, 5'd0), 1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (instr_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 8'h00 || mem_wdata !== 8'h00 ||
            jump_valid !== 1'b0 || jump_target !== 5'h00 || flags !== 4'h0 || illegal !== 1'b0)
            begin bad++; $display("FAIL reset_outs rdy=%b req=%b we=%b addr=%h wd=%h jv=%b jt=%h fl=%b ill=%b", instr_ready, mem_req, mem_we, mem_addr, mem_wdata, jump_valid, jump_target, flags, illegal); end
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
    endtask

    task automatic test_add();
        exec(enc(4'd7, 5'd1, 5'd0, 5'd5), 1);
        exec(enc(4'd7, 5'd2, 5'd0, 5'd3), 1);
        exec(enc(4'd0, 5'd3, 5'd1, 5'd2), 1);
        peek(5'd3);
        exec(enc(4'd0, 5'd1, 5'd1, 5'd1), 1);
        peek(5'd1);
        exec(enc(4'd7, 5'd1, 5'd0, 5'd5), 1);
    endtask

    task automatic test_inc_sub();
        exec(enc(4'd7, 5'd4, 5'd7, 5'd31), 1);
        exec(enc(4'd3, 5'd4, 5'd0, 5'd0), 1);
        peek(5'd4);
        exec(enc(4'd2, 5'd5, 5'd0, 5'd1), 1);
        peek(5'd5);
        exec(enc(4'd4, 5'd5, 5'd7, 5'd0), 1);
        peek(5'd7);
    endtask

    task automatic test_jump();
        exec(enc(4'd1, 5'd1, 5'd2, 5'd0), 1);
        exec(enc(4'd9, 5'd3, 5'h12, 5'd0), 1);
        exec(enc(4'd8, 5'd3, 5'h12, 5'd0), 1);
        exec(enc(4'd8, 5'd1, 5'h0A, 5'd0), 1);
        exec(enc(4'd1, 5'd2, 5'd1, 5'd0), 1);
        exec(enc(4'd8, 5'd3, 5'h15, 5'd0), 1);
    endtask

    task automatic test_mem();
        exec(enc(4'd6, 5'd1, 5'd2, 5'd0), 3);
        exec(enc(4'd5, 5'd2, 5'd6, 5'd0), 2);
        peek(5'd6);
    endtask

    task automatic test_illegal();
        exec(enc(4'd12, 5'd1, 5'd2, 5'd3), 1);
        exec(enc(4'd0, 5'd3, 5'd1, 5'd2), 1);
        exec(enc(4'd15, 5'd1, 5'd1, 5'd1), 1);
        peek(5'd1);
        peek(5'd2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++)
            exec(enc(4'($urandom), 5'($urandom), 5'($urandom), 5'($urandom)), 1 + int'($urandom % 4));
        for (int r = 0; r < 32; r++) peek(5'(r));
    endtask

    task automatic test_reset_mid_mem();
        exec(enc(4'd7, 5'd1, 5'd2, 5'd26), 1);
        exec(enc(4'd7, 5'd2, 5'd0, 5'd9), 1);
        instr = enc(4'd6, 5'd1, 5'd2, 5'd0);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        total++;
        if (mem_req !== 1'b1) begin bad++; $display("FAIL req_before_rst got=%b want=1", mem_req); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_req !== 1'b0 || instr_ready !== 1'b1)
            begin bad++; $display("FAIL async_rst req=%b rdy=%b want 0/1", mem_req, instr_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        total++;
        if (flags !== 4'h0 || illegal !== 1'b0) begin bad++; $display("FAIL post_rst fl=%b ill=%b want 0/0", flags, illegal); end
        peek(5'd1);
        peek(5'd2);
    endtask

    task automatic wexec(input logic [15:0] ins, output logic [15:0] addr, output logic [15:0] wd);
        w_instr = ins;
        w_instr_valid = 1'b1;
        @(negedge clk);
        w_instr_valid = 1'b0;
        addr = '0;
        wd = '0;
        if (ins[15:12] == 4'd6) begin
            @(negedge clk);
            addr = w_mem_addr;
            wd = w_mem_wdata;
            w_mem_ack = 1'b1;
            @(negedge clk);
            w_mem_ack = 1'b0;
        end else @(negedge clk);
    endtask

    task automatic test_wide();
        logic [15:0] a, d;
        wexec({4'd7, 4'd1, 4'hF, 4'hF}, a, d);
        wexec({4'd7, 4'd2, 4'hF, 4'hF}, a, d);
        wexec({4'd0, 4'd3, 4'd1, 4'd2}, a, d);
        total++;
        if (w_flags !== 4'b0000) begin bad++; $display("FAIL wide_add_flags got=%b want=0000", w_flags); end
        wexec({4'd6, 4'd3, 4'd3, 4'd0}, a, d);
        total++;
        if (a !== 16'h01FE || d !== 16'h01FE) begin bad++; $display("FAIL wide_add got=%h/%h want=01fe", a, d); end
        wexec({4'd0, 4'd4, 4'd3, 4'd3}, a, d);
        wexec({4'd6, 4'd4, 4'd4, 4'd0}, a, d);
        total++;
        if (d !== 16'h03FC) begin bad++; $display("FAIL wide_add2 got=%h want=03fc", d); end
        wexec({4'd2, 4'd5, 4'd0, 4'd1}, a, d);
        total++;
        if (w_flags !== 4'b0110) begin bad++; $display("FAIL wide_sub_flags got=%b want=0110", w_flags); end
        wexec({4'd6, 4'd5, 4'd5, 4'd0}, a, d);
        total++;
        if (a !== 16'hFF01 || d !== 16'hFF01) begin bad++; $display("FAIL wide_sub got=%h/%h want=ff01", a, d); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mmem[i] = 8'($urandom);
        model_clear();
        @(negedge clk);
        test_reset();
        test_add();
        test_inc_sub();
        test_jump();
        test_mem();
        test_illegal();
        test_random();
        test_reset_mid_mem();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_exec_unit.md
Name: decode_exec_unit

Overview:
Parametrised instruction decode, control and execute unit for the microprocessor core. It accepts one instruction at a time over a valid/ready handshake and decodes the 4-bit opcode. It executes ALU, move, immediate-load and conditional-jump operations against an internal register file, and drives a req/ack data-memory port for indirect loads and stores. It sits between instruction fetch (upstream) and data memory (downstream) and reports flags and jump redirects back to fetch.

Parameters:
DW, 8, data/register width in bits
RAW, 5, register-address field width; register count NREG = 2**RAW
IW, 4+3*RAW, instruction width (derived, not overridable); 19 at defaults

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
instr_valid  input  1  instruction present on instr
instr_ready  output  1  unit can accept an instruction this cycle
instr  input  IW  opcode[IW-1:IW-4], fa, fb, fc (RAW each, MSB first)
mem_req  output  1  memory request; held until mem_ack
mem_we  output  1  1 = write, 0 = read; stable while mem_req
mem_addr  output  DW  memory address
mem_wdata  output  DW  store data
mem_ack  input  1  memory completed (read data valid same cycle)
mem_rdata  input  DW  read data
jump_valid  output  1  one-cycle pulse: fetch must redirect
jump_target  output  RAW  redirect target
flags  output  4  F0 zero, F1 carry/borrow, F2 negative (MSB), F3 compare-ge
illegal  output  1  sticky: reserved opcode seen

Behaviour:
- Reset (async, rst_n low): FSM to IDLE; all registers, flags and illegal cleared to 0. Outputs instr_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, jump_valid=0, jump_target=0. Reset during MEM_WAIT abandons the transaction; mem_req drops immediately.
- FSM states: IDLE, EXEC, MEM_WAIT.
  - IDLE: instr_ready=1. On valid&&ready, latch instr and go to EXEC.
  - EXEC: instr_ready=0. Execute the latched instruction; return to IDLE, or go to MEM_WAIT for opcode 0101/0110.
  - MEM_WAIT: mem_req=1 until the cycle mem_ack=1; then go to IDLE.
- Register and flag updates for non-memory ops occur on the EXEC→IDLE edge. Throughput is one instruction per 2 cycles; memory ops take 2 + wait cycles.
- Opcodes (R[n] = register n; all arithmetic modulo 2**DW):
  - 0000 ADD: R[fa]=R[fb]+R[fc]. F1=carry out; F0, F2 from the result.
  - 0001 CMP: F3=(R[fa]>=R[fb]) unsigned. Other flags and registers unchanged.
  - 0010 SUB: R[fa]=R[fb]-R[fc]. F1=borrow; F0, F2 from the result.
  - 0011 INC: R[fa]=R[fa]+1. F1=carry on wrap (all-ones → 0, F0=1).
  - 0100 MOV: R[fb]=R[fa]. Flags unchanged.
  - 0101 load: mem_addr=R[fa], mem_we=0. On ack, R[fb]=mem_rdata.
  - 0110 store: mem_addr=R[fb], mem_wdata=R[fa], mem_we=1. No register write on ack.
  - 0111 LDI: R[fa]={fb,fc}, zero-extended or truncated to DW. Flags unchanged.
  - 1000 / 1001: if flags[fa[1:0]] == 0 (1000) or == 1 (1001), pulse jump_valid for the EXEC cycle with jump_target=fb. Otherwise no pulse.
  - 1010–1111: NOP; set illegal (sticky until reset).
- Operand reads use register values as of the EXEC cycle. Same-register source and destination (e.g. ADD R1,R1,R1) uses the old value.
- mem_addr, mem_wdata and mem_we are driven from the EXEC→MEM_WAIT edge and are held stable while mem_req=1. mem_ack outside MEM_WAIT is ignored.
- A jump takes effect by pulse only; the unit has no PC. Fetch must not present the next instruction until the cycle after jump_valid. This is guaranteed because instr_ready=0 during EXEC.

Decomposition:
- Shared package: opcode localparams (OP_ADD … OP_JMP1), flag bit indices, FSM state encoding.
- One sub-module: decode_exec_alu. Purely combinational; takes A, B and op, returns result, carry, zero and negative. Parametrised by DW.

Test Plan:
- Reset, then LDI R1,0x05 and LDI R2,0x03, then ADD R3,R1,R2 → R3=0x08 two cycles after accept; flags=0000; instr_ready low exactly 1 cycle per instruction.
- LDI R4,0xFF; INC R4 → R4=0x00, F0=1, F1=1. Then SUB R5,R0,R1 with R1=5 → R5=0xFB, F1=1, F2=1.
- CMP R1,R2 (5>=3) → F3=1, then 1001 with fa=3, fb=0x12 → jump_valid pulse 1 cycle, jump_target=0x12. Opcode 1000 with the same fields → no pulse.
- Store R1 to (R2), mem_ack delayed 3 cycles → mem_req high 3 cycles, addr=0x03, wdata=0x05, we=1. Load back into R6 → R6=0x05 on ack edge.
- Assert rst_n low mid MEM_WAIT → mem_req=0 asynchronously, all registers and flags read 0 after release, instr_ready=1.
- Opcode 1100 → illegal=1 and stays 1 across subsequent valid instructions; registers unchanged. Repeat the ADD scenario with DW=16, RAW=4 (IW=16) → correct 16-bit results.
